// File: rtl/delta_pkg.sv
// Shared spike codes and reference-update modes for the delta-modulation encoder.
package delta_pkg;

    localparam logic [1:0] SPIKE_NONE = 2'b00;
    localparam logic [1:0] SPIKE_ON   = 2'b01;
    localparam logic [1:0] SPIKE_OFF  = 2'b11;

    typedef enum logic {
        UPD_JUMP = 1'b0,
        UPD_STEP = 1'b1
    } update_mode_e;

endpackage

// File: rtl/delta_compare.sv
// Combinational spike decision and next reference level for one sample.
module delta_compare
    import delta_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] cur_ref,
    input  logic [WIDTH-1:0] threshold,
    input  logic             off_spike_en,
    input  update_mode_e     update_mode,
    output logic [1:0]       spike,
    output logic [WIDTH-1:0] next_ref
);

    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] thr;
    logic signed [WIDTH:0] neg_thr;
    logic        [WIDTH:0] sum;

    assign diff    = $signed({1'b0, in_data}) - $signed({1'b0, cur_ref});
    assign thr     = $signed({1'b0, threshold});
    assign neg_thr = -thr;
    assign sum     = {1'b0, cur_ref} + {1'b0, threshold};

    always_comb begin
        spike    = SPIKE_NONE;
        next_ref = cur_ref;
        if (diff > thr) begin
            spike = SPIKE_ON;
            if (update_mode == UPD_STEP) begin
                next_ref = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
            end else begin
                next_ref = in_data;
            end
        end else if (off_spike_en && (diff < neg_thr)) begin
            spike = SPIKE_OFF;
            if (update_mode == UPD_STEP) begin
                next_ref = (cur_ref > threshold) ? (cur_ref - threshold) : '0;
            end else begin
                next_ref = in_data;
            end
        end
    end

endmodule

// File: rtl/delta_encoder.sv
// Time-multiplexed delta-modulation spike encoder with per-channel reference,
// priming flag and refractory counter; one registered result per accepted sample.
module delta_encoder
    import delta_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int REFRACT  = 2,
    parameter int CHAN_W   = $clog2(CHANNELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [CHAN_W-1:0] in_chan,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [WIDTH-1:0]  threshold,
    input  logic              off_spike_en,
    input  logic              update_mode,
    output logic              out_valid,
    output logic [CHAN_W-1:0] out_chan,
    output logic [1:0]        out_spike
);

    localparam int RCNT_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    logic [WIDTH-1:0]  ref_q    [CHANNELS];
    logic              primed_q [CHANNELS];
    logic [RCNT_W-1:0] rcnt_q   [CHANNELS];

    logic              chan_ok;
    logic [CHAN_W-1:0] sel;
    logic [1:0]        cmp_spike;
    logic [WIDTH-1:0]  cmp_ref;

    assign chan_ok = 32'(in_chan) < CHANNELS;
    // Keep the array index in range even when the request will be ignored.
    assign sel     = chan_ok ? in_chan : '0;

    delta_compare #(
        .WIDTH (WIDTH)
    ) u_compare (
        .in_data      (in_data),
        .cur_ref      (ref_q[sel]),
        .threshold    (threshold),
        .off_spike_en (off_spike_en),
        .update_mode  (update_mode_e'(update_mode)),
        .spike        (cmp_spike),
        .next_ref     (cmp_ref)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                ref_q[i]    <= '0;
                primed_q[i] <= 1'b0;
                rcnt_q[i]   <= '0;
            end
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_spike <= SPIKE_NONE;
        end else if (clear) begin
            for (int i = 0; i < CHANNELS; i++) begin
                ref_q[i]    <= '0;
                primed_q[i] <= 1'b0;
                rcnt_q[i]   <= '0;
            end
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid && chan_ok;
            if (in_valid && chan_ok) begin
                out_chan <= in_chan;
                if (!primed_q[sel]) begin
                    ref_q[sel]    <= in_data;
                    primed_q[sel] <= 1'b1;
                    out_spike     <= SPIKE_NONE;
                end else if (rcnt_q[sel] != '0) begin
                    rcnt_q[sel] <= rcnt_q[sel] - 1'b1;
                    out_spike   <= SPIKE_NONE;
                end else begin
                    ref_q[sel] <= cmp_ref;
                    out_spike  <= cmp_spike;
                    if (cmp_spike != SPIKE_NONE) begin
                        rcnt_q[sel] <= RCNT_W'(REFRACT);
                    end
                end
            end
        end
    end

endmodule
